// File: rtl/prbs31_word_checker.sv
// PRBS-31 (x^31 + x^28 + 1) word checker: acquires lock on the incoming LFSR state words, then flags and counts mispredicted words.
// Latency: every output is registered and updates one cycle after the edge that samples the word.
// Backpressure: none; it accepts a word on every cycle with in_valid=1, and idle cycles freeze all state.
module prbs31_word_checker #(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [30:0]      in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       state
);

    localparam int RUN_MAX = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    typedef enum logic [1:0] {
        SEARCH = 2'b00,
        TRACK  = 2'b01,
        LOCKED = 2'b10
    } state_t;

    state_t            cur_state;
    logic [30:0]       exp_word;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_inc;
    logic              word_match;
    logic              word_zero;

    function automatic logic [30:0] step(input logic [30:0] w);
        return {w[29:0], w[30] ^ w[27]};
    endfunction

    assign run_inc    = run + RUN_W'(1);
    assign word_match = (in_data == exp_word);
    assign word_zero  = (in_data == 31'd0);
    assign state      = cur_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= SEARCH;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= '0;
            exp_word  <= '0;
            run       <= '0;
        end else begin
            err <= 1'b0;
            if (in_valid) begin
                case (cur_state)
                    SEARCH: begin
                        if (!word_zero) begin
                            exp_word  <= step(in_data);
                            run       <= '0;
                            cur_state <= TRACK;
                        end
                    end
                    TRACK: begin
                        if (word_match) begin
                            exp_word <= step(in_data);
                            if (run_inc == RUN_W'(LOCK_CNT)) begin
                                run       <= '0;
                                cur_state <= LOCKED;
                                locked    <= 1'b1;
                            end else begin
                                run <= run_inc;
                            end
                        end else if (!word_zero) begin
                            exp_word <= step(in_data);
                            run      <= '0;
                        end else begin
                            cur_state <= SEARCH;
                        end
                    end
                    LOCKED: begin
                        // Once locked the local generator free-runs; received words only score it.
                        exp_word <= step(exp_word);
                        if (word_match) begin
                            run <= '0;
                        end else begin
                            err <= 1'b1;
                            if (err_cnt != '1)
                                err_cnt <= err_cnt + CNT_W'(1);
                            if (run_inc == RUN_W'(LOSS_CNT)) begin
                                run       <= '0;
                                cur_state <= SEARCH;
                                locked    <= 1'b0;
                            end else begin
                                run <= run_inc;
                            end
                        end
                    end
                    default: begin
                        cur_state <= SEARCH;
                        locked    <= 1'b0;
                        run       <= '0;
                    end
                endcase
            end
            // Clear wins over a same-cycle increment.
            if (clr_cnt)
                err_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_prbs31_word_checker.sv
// Randomized and directed bench for prbs31_word_checker against a spec-level reference model.
module tb_prbs31_word_checker;

    localparam int LOCK_CNT = 4;
    localparam int LOSS_CNT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [30:0] in_data = '0;
    logic        clr_cnt = 1'b0;
    logic        locked, err, locked2, err2;
    logic [15:0] err_cnt;
    logic [1:0]  err_cnt2;
    logic [1:0]  state, state2;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    int          m_state;
    int          m_run;
    logic [30:0] m_exp;
    logic        m_err;
    int          m_cnt;
    int          m_cnt2;

    always #5 clk = ~clk;

    prbs31_word_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked), .err(err), .err_cnt(err_cnt), .state(state)
    );

    prbs31_word_checker #(.LOCK_CNT(LOCK_CNT), .LOSS_CNT(LOSS_CNT), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .clr_cnt(clr_cnt),
        .locked(locked2), .err(err2), .err_cnt(err_cnt2), .state(state2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic [30:0] lfsr_next(input logic [30:0] w);
        logic [31:0] x;
        x = {1'b0, w};
        return 31'(((x << 1) & 32'h7FFF_FFFF) | (((x >> 30) ^ (x >> 27)) & 32'h1));
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_exp = '0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_step(input logic v, input logic [30:0] d, input logic c);
        m_err = 0;
        if (v) begin
            if (m_state == 0) begin
                if (d != 0) begin m_exp = lfsr_next(d); m_run = 0; m_state = 1; end
            end else if (m_state == 1) begin
                if (d == m_exp) begin
                    m_exp = lfsr_next(d);
                    m_run = m_run + 1;
                    if (m_run == LOCK_CNT) begin m_state = 2; m_run = 0; end
                end else if (d != 0) begin
                    m_exp = lfsr_next(d); m_run = 0;
                end else begin
                    m_state = 0;
                end
            end else begin
                if (d == m_exp) m_run = 0;
                else begin
                    m_err = 1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    if (m_cnt2 < 3) m_cnt2 = m_cnt2 + 1;
                    m_run = m_run + 1;
                    if (m_run == LOSS_CNT) begin m_state = 0; m_run = 0; end
                end
                m_exp = lfsr_next(m_exp);
            end
        end
        if (c) begin m_cnt = 0; m_cnt2 = 0; end
    endtask

    task automatic check_all();
        chk("state", 32'(state), 32'(m_state));
        chk("locked", 32'(locked), 32'(m_state == 2));
        chk("err", 32'(err), 32'(m_err));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        chk("err_cnt_sat", 32'(err_cnt2), 32'(m_cnt2));
    endtask

    // Drive one cycle, advance the model on the same edge, sample 1 ns later.
    task automatic apply(input logic v, input logic [30:0] d, input logic c);
        in_valid = v; in_data = d; clr_cnt = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
        check_all();
        in_valid = 1'b0; clr_cnt = 1'b0;
    endtask

    task automatic feed_good();
        apply(1'b1, (m_state == 0) ? 31'h1234_567 : m_exp, 1'b0);
    endtask

    task automatic feed_bad();
        apply(1'b1, m_exp ^ 31'h0000_0500, 1'b0);
    endtask

    initial begin
        logic [30:0] w;
        int r;
        model_reset();
        #12;
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_locked", 32'(locked), 32'd0);
        chk("reset_err_cnt", 32'(err_cnt), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Acquisition from a walking-one seed
        apply(1'b1, 31'h1, 1'b0);
        chk("track_after_seed", 32'(state), 32'd1);
        apply(1'b1, 31'h2, 1'b0);
        apply(1'b1, 31'h4, 1'b0);
        apply(1'b1, 31'h8, 1'b0);
        chk("not_yet_locked", 32'(locked), 32'd0);
        apply(1'b1, 31'h10, 1'b0);
        chk("locked_after_0x10", 32'(locked), 32'd1);

        // Single corrupted word, then the free-running prediction continues
        apply(1'b1, 31'h25, 1'b0);
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_cnt_one", 32'(err_cnt), 32'd1);
        apply(1'b1, 31'h40, 1'b0);
        chk("err_one_cycle", 32'(err), 32'd0);
        chk("still_locked", 32'(locked), 32'd1);

        // Idle gap mid-lock
        for (int i = 0; i < 5; i++) apply(1'b0, 31'h0, 1'b0);
        feed_good();
        chk("gap_keeps_lock", 32'(locked), 32'd1);

        // Three consecutive errors drop lock
        feed_bad(); feed_bad();
        chk("locked_after_2_bad", 32'(locked), 32'd1);
        feed_bad();
        chk("lock_lost", 32'(locked), 32'd0);
        chk("err_cnt_four", 32'(err_cnt), 32'd4);

        // Zero words are ignored in SEARCH and abort TRACK
        for (int i = 0; i < 3; i++) apply(1'b1, 31'h0, 1'b0);
        chk("zero_stays_search", 32'(state), 32'd0);
        feed_good();
        apply(1'b1, 31'h0, 1'b0);
        chk("zero_in_track", 32'(state), 32'd0);

        // Re-lock with seed + 4 matches, then 7 isolated errors
        for (int i = 0; i < 5; i++) feed_good();
        chk("relocked", 32'(locked), 32'd1);
        apply(1'b0, 31'h0, 1'b1);
        for (int i = 0; i < 7; i++) begin feed_bad(); feed_good(); end
        chk("err_cnt_seven", 32'(err_cnt), 32'd7);
        chk("sat_holds_3", 32'(err_cnt2), 32'd3);
        apply(1'b1, m_exp ^ 31'h1, 1'b1);
        chk("clr_err_pulse", 32'(err), 32'd1);
        chk("clr_wins", 32'(err_cnt), 32'd0);

        // Asynchronous reset while locked
        feed_good(); feed_bad();
        #2 rst = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_err", 32'(err), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_state", 32'(state), 32'd0);
        w = m_exp;
        model_reset();
        #3 rst = 1'b1;
        @(posedge clk); #1;
        apply(1'b1, w, 1'b0);
        chk("reacq_track", 32'(state), 32'd1);
        w = lfsr_next(w);
        for (int i = 0; i < 4; i++) begin apply(1'b1, w, 1'b0); w = lfsr_next(w); end
        chk("reacq_locked", 32'(locked), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 65)      w = (m_state == 0) ? 31'($urandom_range(1, 32'h7FFF_FFFF)) : m_exp;
            else if (r < 85) w = m_exp ^ (31'h1 << $urandom_range(0, 30));
            else if (r < 90) w = '0;
            else             w = 31'($urandom);
            apply($urandom_range(0, 3) != 0, w, $urandom_range(0, 63) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/prbs31_word_checker.md
# prbs31_word_checker

PRBS-31 word checker downstream of the 31-bit double-register pipeline stage. Each valid 31-bit word is the full state of a PRBS-31 LFSR (x^31 + x^28 + 1). The block locks onto the incoming sequence and predicts every following word. While locked, it flags and counts mismatching words, and drops lock after a run of consecutive errors.

## Interface
- LOCK_CNT, 4: consecutive correct predictions required to enter LOCKED (≥1)
- LOSS_CNT, 3: consecutive mispredictions in LOCKED that force re-search (≥1)
- CNT_W, 16: error counter width
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- in_valid  input  1  in_data is a new word this cycle
- in_data  input  31  LFSR state word from upstream pipeline
- clr_cnt  input  1  synchronous clear of err_cnt
- locked  output  1  checker is in LOCKED
- err  output  1  one-cycle pulse per mispredicted word while LOCKED
- err_cnt  output  CNT_W  saturating mismatch count
- state  output  2  00 SEARCH, 01 TRACK, 10 LOCKED

## Operation
- Step function: step(w) = {w[29:0], w[30]^w[27]}.
- Internal regs: exp[30:0] (expected next word), run counter (enough bits for max(LOCK_CNT, LOSS_CNT)), state.
- All decisions apply only on cycles with in_valid=1. With in_valid=0, no state, exp, run or err change (err=0).
- SEARCH:
  - in_data==0 is illegal and ignored (stay in SEARCH).
  - Any nonzero word: exp<=step(in_data), run<=0, go to TRACK.
- TRACK:
  - in_data==exp: exp<=step(in_data), run++. If run+1==LOCK_CNT, go to LOCKED with run<=0.
  - Mismatch, nonzero word: re-seed exp<=step(in_data), run<=0, stay in TRACK.
  - Mismatch, zero word: go to SEARCH.
  - No err/err_cnt activity in TRACK.
- LOCKED:
  - exp always free-runs: exp<=step(exp). The received word is never used to re-seed.
  - Match: run<=0.
  - Mismatch: err=1, err_cnt+1 (saturate at all-ones), run++. If run+1==LOSS_CNT, go to SEARCH with run<=0.
- clr_cnt=1: err_cnt<=0. This has priority over a same-cycle increment, and that increment is lost.
- LOCK_CNT=1: a single correct prediction after seeding locks.

## Timing
- Reset (rst=0, asynchronous): state=SEARCH, locked=0, err=0, err_cnt=0, exp=0, run=0. Takes effect immediately, including mid-lock. Release is synchronous to the next clk edge.
- All outputs are registered, with 1-cycle latency from the sampling edge of the word:
  - err is high for the cycle after the edge that sampled the bad word.
  - locked rises the cycle after the edge that sampled the LOCK_CNT-th match.
- locked == (state==LOCKED), with no lag.
- Back-to-back valid words at full rate are supported. Arbitrary in_valid gaps are tolerated without lock loss.
- Counter saturation: at err_cnt = 2^CNT_W−1, further errors still pulse err, but the count holds.

## Test plan
- Reset, then valid words 0x00000001, 0x00000002, 0x00000004, 0x00000008, 0x00000010 back-to-back -> state 00→01 after the first word; locked=1 one cycle after 0x10 is sampled; err never asserted; err_cnt=0.
- Locked on the sequence above, next word 0x00000025 instead of 0x00000020, then 0x00000040 -> err high exactly one cycle, err_cnt=1, locked stays 1, the 0x40 word matches.
- Locked, three consecutive corrupted words -> err_cnt=3, locked falls one cycle after the third; state=00. Re-lock requires seed + 4 matches.
- In SEARCH, words 0x00000000 ×3 -> state stays 00; in TRACK, word 0x0 -> state 00. Valid gaps of 5 idle cycles mid-sequence -> lock unaffected.
- clr_cnt=1 on the same cycle as a LOCKED mismatch with err_cnt=7 -> err pulses, err_cnt=0. CNT_W=2 with 5 errors -> err_cnt holds at 3.
- Locked, rst driven low between clock edges -> locked, err, err_cnt, state read 0 before the next edge. After release, feeding the same words requires full re-acquisition.
